// File: rtl/instr_fetch_queue.sv
// Instruction RAM with sequential auto-fetch into a QDEPTH-entry queue; head entry presented pre-split.
// Optional IFQ_STATS_EN adds saturating pop (fetch_count) and redirect (flush_count) counters.
module instr_fetch_queue #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [5:0]        out_op,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm,
    output logic              busy
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [15:0]       flush_count
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic               r_rd_valid;
    logic [31:0]        r_rd_pc;
    logic [31:0]        r_rd_data;
    logic [31:0]        r_mem     [DEPTH];
    logic [31:0]        r_q_pc    [QDEPTH];
    logic [31:0]        r_q_instr [QDEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [ADDR_W-1:0]  w_addr;
    logic [CNT_W:0]     w_occ;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_head_instr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy includes the in-flight read so a full queue can never be overrun.
    assign w_addr  = r_pc[ADDR_W+1:2];
    assign w_occ   = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_rd_valid);
    assign w_issue = (r_state == S_RUN) && !load_en && !redirect_valid
                     && (w_occ < (CNT_W+1)'(QDEPTH));
    assign w_push  = r_rd_valid && !redirect_valid;
    assign w_pop   = out_valid && out_ready && !redirect_valid;

    // Control: FSM, PC, read stage and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_state <= S_RUN;
            end

            if (redirect_valid) begin
                r_pc <= redirect_pc & ~32'd3;
            end else if (r_state == S_IDLE && start) begin
                r_pc <= '0;
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end

            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_pc <= r_pc;
            end

            if (redirect_valid) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= ptr_inc(r_tail);
                if (w_pop)  r_head <= ptr_inc(r_head);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Instruction RAM: a load write and a fetch read never share a cycle.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[w_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_rd_pc;
            r_q_instr[r_tail] <= r_rd_data;
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_pc       = out_valid ? r_q_pc[r_head] : '0;
    assign w_head_instr = out_valid ? r_q_instr[r_head] : '0;
    assign out_instr    = w_head_instr;
    assign out_op       = w_head_instr[31:26];
    assign out_rs       = w_head_instr[25:21];
    assign out_rt       = w_head_instr[20:16];
    assign out_rd       = w_head_instr[15:11];
    assign out_funct    = w_head_instr[5:0];
    assign out_imm      = w_head_instr[15:0];
    assign busy         = (r_state == S_RUN);

`ifdef IFQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (w_pop && fetch_count != '1) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect_valid && flush_count != '1) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stimulus queues expected PCs, a negedge monitor checks each pop.
module tb_instr_fetch_queue;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, load_en, redirect_valid, out_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data, redirect_pc;
    logic              out_valid, busy;
    logic [31:0]       out_pc, out_instr;
    logic [5:0]        out_op, out_funct;
    logic [4:0]        out_rs, out_rt, out_rd;
    logic [15:0]       out_imm;
`ifdef IFQ_STATS_EN
    logic [31:0]       fetch_count;
    logic [15:0]       flush_count;
`endif

    int checks   = 0;
    int failures = 0;
    int pops_seen = 0;
    int flushes_seen = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_q [$];

    instr_fetch_queue #(.ADDR_W(ADDR_W), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_op(out_op), .out_rs(out_rs),
        .out_rt(out_rt), .out_rd(out_rd), .out_funct(out_funct),
        .out_imm(out_imm), .busy(busy)
`ifdef IFQ_STATS_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected fetch stream: consecutive word PCs from the given start point.
    task automatic arm(input logic [31:0] pc0);
        exp_q.delete();
        for (int i = 0; i < 400; i++) exp_q.push_back((pc0 & ~32'd3) + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = ADDR_W'(idx);
        load_data = data;
        mem_m[idx] = data;
        step();
        load_en = 1'b0;
    endtask

    function automatic logic [42:0] fields(input logic [31:0] w);
        return {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]};
    endfunction

    // Monitor: a handshake seen here becomes a pop at the next rising edge.
    always @(negedge clk) begin
        logic [31:0] p;
        logic [31:0] w;
        if (rst) begin
            pops_seen    = 0;
            flushes_seen = 0;
        end else begin
            if (redirect_valid) flushes_seen++;
            if (out_valid && out_ready && !redirect_valid) begin
                pops_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {32'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    p = exp_q.pop_front();
                    w = mem_m[p[ADDR_W+1:2]];
                    chk("pop_pc", {32'd0, out_pc}, {32'd0, p});
                    chk("pop_instr", {32'd0, out_instr}, {32'd0, w});
                    chk("pop_fields",
                        {21'd0, out_op, out_rs, out_rt, out_rd, out_funct, out_imm},
                        {21'd0, fields(w)});
                end
            end
            if (!out_valid) begin
                chk("empty_zero",
                    {11'd0, out_pc[20:0] | 21'(out_pc >> 21), out_op, out_rs, out_rt, out_rd, out_funct, out_imm},
                    64'd0);
                chk("empty_instr", {32'd0, out_instr}, 64'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step(); step();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        step();

        // RAM load while idle: known head words, random remainder.
        load_word(0, 32'h2000_0000);
        load_word(1, 32'h2021_0001);
        load_word(2, 32'h2042_0002);
        load_word(3, 32'h2063_0003);
        for (int i = 4; i < int'(DEPTH); i++) load_word(i, $urandom);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // Start latency and back-to-back pops.
        arm(32'd0);
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("lat_e0", {63'd0, out_valid}, 64'd0);
        step();
        chk("lat_e1", {63'd0, out_valid}, 64'd0);
        step();
        chk("lat_e2_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_e2_pc", {32'd0, out_pc}, 64'd0);
        step();
        chk("seq_pc4", {32'd0, out_pc}, 64'd4);
        chk("seq_op", {58'd0, out_op}, 64'h08);
        chk("seq_rs_rt", {54'd0, out_rs, out_rt}, {54'd0, 5'd1, 5'd1});
        chk("seq_imm", {48'd0, out_imm}, 64'h0001);
        step();
        chk("seq_pc8", {32'd0, out_pc}, 64'd8);
        step();
        chk("seq_pc12", {32'd0, out_pc}, 64'd12);

        // Backpressure: queue fills, head holds, stream resumes without loss.
        rst = 1'b1; out_ready = 1'b0;
        step();
        rst = 1'b0;
        arm(32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("full_valid", {63'd0, out_valid}, 64'd1);
        chk("full_hold_pc", {32'd0, out_pc}, 64'd0);
        out_ready = 1'b1;
        repeat (20) step();

        // Redirect to a misaligned target with a full queue and ready high.
        out_ready = 1'b0;
        repeat (8) step();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_000B;
        arm(32'h0000_0008);
        step();
        redirect_valid = 1'b0;
        chk("redir_flush", {63'd0, out_valid}, 64'd0);
        step();
        chk("redir_e1", {63'd0, out_valid}, 64'd0);
        step();
        chk("redir_e2_pc", {32'd0, out_pc}, 64'h8);
        chk("redir_e2_instr", {32'd0, out_instr}, {32'd0, mem_m[2]});
        step();
        chk("redir_e3_pc", {32'd0, out_pc}, 64'hC);

        // Address wrap: PC keeps counting while the RAM index wraps.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_00FC;
        arm(32'h0000_00FC);
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("wrap_pc_fc", {32'd0, out_pc}, 64'hFC);
        chk("wrap_instr63", {32'd0, out_instr}, {32'd0, mem_m[63]});
        step();
        chk("wrap_pc_100", {32'd0, out_pc}, 64'h100);
        chk("wrap_instr0", {32'd0, out_instr}, {32'd0, mem_m[0]});

        // Loads in RUN stall issue; the stream then resumes with the new words.
        for (int i = 10; i <= 12; i++) begin
            load_en = 1'b1;
            load_addr = ADDR_W'(i);
            load_data = $urandom;
            mem_m[i] = load_data;
            step();
        end
        load_en = 1'b0;
        chk("load_drained", {63'd0, out_valid}, 64'd0);
        step();
        chk("load_resume_e1", {63'd0, out_valid}, 64'd0);
        step();
        chk("load_resume_e2", {63'd0, out_valid}, 64'd1);
        repeat (20) step();

        // Random backpressure, redirects and content-preserving loads.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 99) < 70);
            redirect_valid = 1'b0;
            load_en = 1'b0;
            if ($urandom_range(0, 99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
                arm(redirect_pc);
            end else if ($urandom_range(0, 99) < 4) begin
                load_en = 1'b1;
                load_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                load_data = mem_m[load_addr];
            end
            step();
        end
        redirect_valid = 1'b0;
        load_en = 1'b0;

        // Reset mid-stream with entries queued; RAM survives.
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        arm(32'd0);
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        repeat (4) step();
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
`ifdef IFQ_STATS_EN
        chk("stat_fetch", {32'd0, fetch_count}, 64'(pops_seen));
        chk("stat_flush", {48'd0, flush_count}, 64'(flushes_seen));
`endif
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_pc", {32'd0, out_pc}, 64'd0);
        chk("rst_instr", {32'd0, out_instr}, 64'd0);
        out_ready = 1'b1;
        repeat (5) step();
        chk("rst_no_output", {63'd0, out_valid}, 64'd0);
        arm(32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("restart_pc", {32'd0, out_pc}, 64'd0);
        chk("restart_instr", {32'd0, out_instr}, 64'h2000_0000);
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
